// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 registered mux / arbiter.
package mux_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // Select-index width; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, cyclically.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int idx;
    int win;

    // Scan offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        idx     = 0;
        win     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                gnt_any = 1'b1;
                win     = idx;
            end
        end
        if (gnt_any) gnt[win] = 1'b1;
        gnt_idx = win[SEL_W-1:0];
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// N-input registered multiplexer with valid/ready, explicit-select or round-robin grant.
module mux_arb_nx1
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MUX_MODE_SEL,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic             load;
    logic             xfer;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [WIDTH-1:0] data_mux;

    logic [WIDTH-1:0] data_reg;
    logic [SEL_W-1:0] ch_reg;
    logic             valid_reg;

    // Combinational out_ready -> in_ready path is deliberate: no bubble on refill.
    assign load = !valid_reg || out_ready;
    assign xfer = gnt_any && load && (|(in_valid & gnt));

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SEL_W-1:0] ptr_reg;
            logic [SEL_W-1:0] ptr_next;
            logic             unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(
                .N     (N),
                .SEL_W (SEL_W)
            ) u_arb (
                .req     (in_valid),
                .ptr     (ptr_reg),
                .gnt     (gnt),
                .gnt_idx (gnt_idx),
                .gnt_any (gnt_any)
            );

            // Explicit wrap keeps the pointer in range for non-power-of-2 N.
            always_comb begin
                ptr_next = ptr_reg;
                if (xfer) ptr_next = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ptr_reg <= '0;
                else        ptr_reg <= ptr_next;
            end
        end else begin : g_sel
            assign gnt_any = (int'(sel) < N);
            assign gnt_idx = sel;
            for (genvar gi = 0; gi < N; gi++) begin : g_onehot
                assign gnt[gi] = gnt_any && (int'(sel) == gi);
            end
        end
    endgenerate

    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign in_ready[gi] = gnt[gi] & load;
    end

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < N; i++) begin
            data_mux = data_mux | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            ch_reg    <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            if (xfer) begin
                data_reg  <= data_mux;
                ch_reg    <= gnt_idx;
                valid_reg <= 1'b1;
            end else begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = data_reg;
    assign out_ch    = ch_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1 across select and round-robin configurations.
module tb_mux_arb_nx1;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    // d0: select mode, N=4, W=32
    logic [127:0] d0_in_data;
    logic [3:0]   d0_in_valid, d0_in_ready;
    logic [1:0]   d0_sel, d0_out_ch;
    logic [31:0]  d0_out_data;
    logic         d0_out_valid, d0_out_ready;

    // d1: round-robin, N=3, W=8
    logic [23:0]  d1_in_data;
    logic [2:0]   d1_in_valid, d1_in_ready;
    logic [1:0]   d1_sel, d1_out_ch;
    logic [7:0]   d1_out_data;
    logic         d1_out_valid, d1_out_ready;

    // d2: round-robin, N=4, W=16
    logic [63:0]  d2_in_data;
    logic [3:0]   d2_in_valid, d2_in_ready;
    logic [1:0]   d2_sel, d2_out_ch;
    logic [15:0]  d2_out_data;
    logic         d2_out_valid, d2_out_ready;

    // d3: select mode, N=5, W=8
    logic [39:0]  d3_in_data;
    logic [4:0]   d3_in_valid, d3_in_ready;
    logic [2:0]   d3_sel, d3_out_ch;
    logic [7:0]   d3_out_data;
    logic         d3_out_valid, d3_out_ready;

    mux_arb_nx1 #(.WIDTH(32), .N(4), .MODE(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0_in_data), .in_valid(d0_in_valid),
        .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
        .out_ch(d0_out_ch), .out_valid(d0_out_valid), .out_ready(d0_out_ready));

    mux_arb_nx1 #(.WIDTH(8), .N(3), .MODE(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1_in_data), .in_valid(d1_in_valid),
        .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
        .out_ch(d1_out_ch), .out_valid(d1_out_valid), .out_ready(d1_out_ready));

    mux_arb_nx1 #(.WIDTH(16), .N(4), .MODE(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2_in_data), .in_valid(d2_in_valid),
        .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data),
        .out_ch(d2_out_ch), .out_valid(d2_out_valid), .out_ready(d2_out_ready));

    mux_arb_nx1 #(.WIDTH(8), .N(5), .MODE(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
        .in_ready(d3_in_ready), .sel(d3_sel), .out_data(d3_out_data),
        .out_ch(d3_out_ch), .out_valid(d3_out_valid), .out_ready(d3_out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d0_in_data = '0; d0_in_valid = '0; d0_sel = 2'd0; d0_out_ready = 1'b0;
        d1_in_data = '0; d1_in_valid = '0; d1_sel = 2'd0; d1_out_ready = 1'b0;
        d2_in_data = '0; d2_in_valid = '0; d2_sel = 2'd0; d2_out_ready = 1'b0;
        d3_in_data = '0; d3_in_valid = '0; d3_sel = 3'd0; d3_out_ready = 1'b0;
        #3;
        vectors++;
        if (d0_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", d0_out_valid); end
        vectors++;
        if (d0_out_data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", d0_out_data); end
        vectors++;
        if (d0_out_ch !== 2'd0) begin miscompares++; $display("FAIL reset_ch got %0d want 0", d0_out_ch); end
        vectors++;
        if (d0_in_ready !== 4'b0001) begin miscompares++; $display("FAIL reset_ready_d0 got %b want 0001", d0_in_ready); end
        vectors++;
        if (d3_in_ready !== 5'b00001) begin miscompares++; $display("FAIL reset_ready_d3 got %b want 00001", d3_in_ready); end
        vectors++;
        if (d1_in_ready !== 3'b000) begin miscompares++; $display("FAIL reset_ready_d1 got %b want 000", d1_in_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset: released");
    endtask

    task automatic test_sel_basic();
        d0_out_ready = 1'b1;
        d0_sel = 2'd2;
        d0_in_valid = 4'b0100;
        d0_in_data[2*32 +: 32] = 32'hDEADBEEF;
        #1;
        vectors++;
        if (d0_in_ready !== 4'b0100) begin miscompares++; $display("FAIL sel_ready got %b want 0100", d0_in_ready); end
        tick();
        $display("sel_basic: ch2 word out_data=%h", d0_out_data);
        vectors++;
        if (d0_out_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sel_data got %h want deadbeef", d0_out_data); end
        vectors++;
        if (d0_out_ch !== 2'd2) begin miscompares++; $display("FAIL sel_ch got %0d want 2", d0_out_ch); end
        vectors++;
        if (d0_out_valid !== 1'b1) begin miscompares++; $display("FAIL sel_valid got %b want 1", d0_out_valid); end
        d0_in_valid = 4'b0000;
        tick();
        vectors++;
        if (d0_out_valid !== 1'b0) begin miscompares++; $display("FAIL sel_drain_valid got %b want 0", d0_out_valid); end
        vectors++;
        if (d0_out_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sel_drain_data got %h want deadbeef", d0_out_data); end
    endtask

    task automatic test_backpressure();
        d0_out_ready = 1'b0;
        d0_sel = 2'd0;
        d0_in_valid = 4'b0001;
        d0_in_data[0 +: 32] = 32'h11111111;
        tick();
        vectors++;
        if (d0_out_data !== 32'h11111111) begin miscompares++; $display("FAIL bp_first got %h want 11111111", d0_out_data); end
        d0_in_data[0 +: 32] = 32'h22222222;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (d0_in_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_ready[%0d] got %b want 0000", c, d0_in_ready); end
            tick();
            $display("backpressure: stall %0d out_data=%h", c, d0_out_data);
            vectors++;
            if (d0_out_data !== 32'h11111111 || d0_out_valid !== 1'b1) begin
                miscompares++; $display("FAIL bp_hold[%0d] got %h/%b want 11111111/1", c, d0_out_data, d0_out_valid);
            end
        end
        d0_out_ready = 1'b1;
        d0_sel = 2'd1;
        d0_in_valid = 4'b0010;
        d0_in_data[1*32 +: 32] = 32'h12345678;
        #1;
        vectors++;
        if (d0_in_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_refill_ready got %b want 0010", d0_in_ready); end
        tick();
        vectors++;
        if (d0_out_data !== 32'h12345678 || d0_out_ch !== 2'd1 || d0_out_valid !== 1'b1) begin
            miscompares++; $display("FAIL bp_refill got %h/%0d/%b want 12345678/1/1", d0_out_data, d0_out_ch, d0_out_valid);
        end
        d0_in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        d0_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d0_sel = 2'(i);
            d0_in_valid = 4'(1 << i);
            d0_in_data[i*32 +: 32] = 32'hC0DE0000 + i;
            tick();
            $display("back_to_back: ch%0d out_data=%h", i, d0_out_data);
            vectors++;
            if (d0_out_data !== 32'hC0DE0000 + i || d0_out_ch !== 2'(i) || d0_out_valid !== 1'b1) begin
                miscompares++; $display("FAIL b2b[%0d] got %h/%0d/%b want %h/%0d/1", i, d0_out_data, d0_out_ch, d0_out_valid, 32'hC0DE0000 + i, i);
            end
        end
        d0_in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_rr_fair();
        int exp_ch;
        d1_out_ready = 1'b1;
        d1_in_data = {8'hA2, 8'hA1, 8'hA0};
        d1_in_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            exp_ch = c % 3;
            #1;
            vectors++;
            if (d1_in_ready !== 3'(1 << exp_ch)) begin miscompares++; $display("FAIL rr_ready[%0d] got %b want ch%0d", c, d1_in_ready, exp_ch); end
            tick();
            $display("rr_fair: cycle %0d out_ch=%0d", c, d1_out_ch);
            vectors++;
            if (d1_out_ch !== 2'(exp_ch) || d1_out_data !== 8'hA0 + 8'(exp_ch)) begin
                miscompares++; $display("FAIL rr_seq[%0d] got ch%0d/%h want ch%0d/%h", c, d1_out_ch, d1_out_data, exp_ch, 8'hA0 + 8'(exp_ch));
            end
        end
        d1_in_valid = 3'b000;
        tick();
    endtask

    task automatic test_rr_wrap();
        d2_out_ready = 1'b1;
        d2_in_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        d2_in_valid = 4'b0001;
        tick();
        vectors++;
        if (d2_out_ch !== 2'd0) begin miscompares++; $display("FAIL wrap_seed got ch%0d want ch0", d2_out_ch); end
        d2_out_ready = 1'b0;
        d2_in_valid = 4'b1111;
        #1;
        vectors++;
        if (d2_in_ready !== 4'b0000) begin miscompares++; $display("FAIL wrap_bp_ready got %b want 0000", d2_in_ready); end
        tick();
        d2_out_ready = 1'b1;
        d2_in_valid = 4'b1001;
        #1;
        vectors++;
        if (d2_in_ready !== 4'b1000) begin miscompares++; $display("FAIL wrap_ready_ch3 got %b want 1000", d2_in_ready); end
        tick();
        $display("rr_wrap: out_ch=%0d out_data=%h", d2_out_ch, d2_out_data);
        vectors++;
        if (d2_out_ch !== 2'd3 || d2_out_data !== 16'h3333) begin miscompares++; $display("FAIL wrap_ch3 got ch%0d/%h want ch3/3333", d2_out_ch, d2_out_data); end
        vectors++;
        if (d2_in_ready !== 4'b0001) begin miscompares++; $display("FAIL wrap_ready_ch0 got %b want 0001", d2_in_ready); end
        tick();
        $display("rr_wrap: out_ch=%0d out_data=%h", d2_out_ch, d2_out_data);
        vectors++;
        if (d2_out_ch !== 2'd0 || d2_out_data !== 16'h0000 || d2_out_valid !== 1'b1) begin
            miscompares++; $display("FAIL wrap_ch0 got ch%0d/%h/%b want ch0/0000/1", d2_out_ch, d2_out_data, d2_out_valid);
        end
        d2_in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_sel_oob();
        d3_out_ready = 1'b1;
        d3_sel = 3'd1;
        d3_in_valid = 5'b00010;
        d3_in_data[1*8 +: 8] = 8'h5A;
        tick();
        vectors++;
        if (d3_out_valid !== 1'b1 || d3_out_ch !== 3'd1) begin miscompares++; $display("FAIL oob_seed got %b/ch%0d want 1/ch1", d3_out_valid, d3_out_ch); end
        d3_sel = 3'd5;
        d3_in_valid = 5'b11111;
        #1;
        vectors++;
        if (d3_in_ready !== 5'b00000) begin miscompares++; $display("FAIL oob_ready got %b want 00000", d3_in_ready); end
        tick();
        $display("sel_oob: out_valid=%b out_ch=%0d", d3_out_valid, d3_out_ch);
        vectors++;
        if (d3_out_valid !== 1'b0 || d3_out_ch !== 3'd1 || d3_out_data !== 8'h5A) begin
            miscompares++; $display("FAIL oob_drop got %b/ch%0d/%h want 0/ch1/5a", d3_out_valid, d3_out_ch, d3_out_data);
        end
        d3_in_valid = 5'b00000;
    endtask

    task automatic test_async_reset();
        d0_out_ready = 1'b1;
        d0_sel = 2'd3;
        d0_in_valid = 4'b1000;
        d0_in_data[3*32 +: 32] = 32'hA5A5A5A5;
        d2_out_ready = 1'b1;
        d2_in_valid = 4'b0010;
        tick();
        vectors++;
        if (d0_out_data !== 32'hA5A5A5A5 || d0_out_valid !== 1'b1) begin
            miscompares++; $display("FAIL arst_load got %h/%b want a5a5a5a5/1", d0_out_data, d0_out_valid);
        end
        d0_in_valid = 4'b0000;
        d0_out_ready = 1'b0;
        d2_in_valid = 4'b1111;
        #1;
        vectors++;
        if (d2_in_ready !== 4'b0100) begin miscompares++; $display("FAIL arst_ptr_pre got %b want 0100", d2_in_ready); end
        #1;
        rst_n = 1'b0;
        #1;
        $display("async_reset: out_valid=%b out_data=%h", d0_out_valid, d0_out_data);
        vectors++;
        if (d0_out_valid !== 1'b0 || d0_out_data !== 32'h0 || d0_out_ch !== 2'd0) begin
            miscompares++; $display("FAIL arst_regs got %b/%h/%0d want 0/0/0", d0_out_valid, d0_out_data, d0_out_ch);
        end
        vectors++;
        if (d2_in_ready !== 4'b0001 || d2_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL arst_ptr got %b/%b want 0001/0", d2_in_ready, d2_out_valid);
        end
        tick();
        rst_n = 1'b1;
        d2_in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_sel_basic();
        test_backpressure();
        test_back_to_back();
        test_rr_fair();
        test_rr_wrap();
        test_sel_oob();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
